stream_cipher_ctrl: RTL and testbench

Sequencing controller for the 8-bit LFSR keystream generator (prng block) in the data-encryption path. It accepts a job (seed + byte count), loads the seed into the generator and streams plaintext bytes in over a valid/ready handshake. Each accepted byte is XORed with the current keystream byte, and the generator is stepped exactly once per byte. Ciphertext leaves through a one-entry registered valid/ready output, and the block raises a done pulse when the job completes.

---
 rtl/stream_cipher_ctrl.sv | 90 +++++++++
 tb/tb_stream_cipher_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_cipher_ctrl.sv
// Job sequencer for the 8-bit LFSR keystream generator.
// It seeds the generator and XORs each plaintext byte into a registered ciphertext slot.
module stream_cipher_ctrl #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       seed,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] bytes_left,
   input  logic             pt_valid,
   input  logic [7:0]       pt_data,
   output logic             pt_ready,
   output logic             ct_valid,
   output logic [7:0]       ct_data,
   input  logic             ct_ready,
   output logic             prng_load,
   output logic [7:0]       prng_seed,
   output logic             prng_step,
   input  logic [7:0]       prng_in
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   logic [2:0] state;
   logic [2:0] state_n;
   logic [7:0] seed_q;
   logic       accept;
   logic       kill;

   assign kill      = abort && (state != S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign pt_ready  = (state == S_RUN) && (!ct_valid || ct_ready);
   // An abort wins over a byte offered in the same cycle.
   assign accept    = pt_valid && pt_ready && !abort;
   assign prng_step = accept;
   assign prng_load = (state == S_LOAD);
   assign prng_seed = seed_q;

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_LOAD;
         S_LOAD:  state_n = (bytes_left != '0) ? S_RUN : S_DONE;
         S_RUN:   if (accept && bytes_left == ONE) state_n = S_DRAIN;
         S_DRAIN: if (!ct_valid || ct_ready) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (kill) state_n = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         seed_q     <= '0;
         bytes_left <= '0;
         ct_valid   <= 1'b0;
         ct_data    <= '0;
      end else begin
         state <= state_n;
         if (state == S_IDLE && start) begin
            seed_q     <= seed;
            bytes_left <= len;
         end
         if (kill) begin
            ct_valid   <= 1'b0;
            bytes_left <= '0;
         end else if (accept) begin
            ct_data    <= pt_data ^ prng_in;
            ct_valid   <= 1'b1;
            bytes_left <= bytes_left - ONE;
         end else if (ct_valid && ct_ready) begin
            ct_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// Scoreboard bench for stream_cipher_ctrl with an LFSR generator model.
// Expected ciphertext is pt ^ (keystream byte n of the job seed).
module tb_stream_cipher_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] seed;
   logic [7:0] len;
   logic       abort;
   logic       busy;
   logic       done;
   logic [7:0] bytes_left;
   logic       pt_valid;
   logic [7:0] pt_data;
   logic       pt_ready;
   logic       ct_valid;
   logic [7:0] ct_data;
   logic       ct_ready;
   logic       prng_load;
   logic [7:0] prng_seed;
   logic       prng_step;
   logic [7:0] prng_in;

   int checks = 0;
   int errors = 0;
   int done_cnt, step_cnt, load_cnt, prdy_cnt, ctv_cnt;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] gen;

   stream_cipher_ctrl #(.LEN_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .len(len),
      .abort(abort), .busy(busy), .done(done), .bytes_left(bytes_left),
      .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
      .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
      .prng_load(prng_load), .prng_seed(prng_seed),
      .prng_step(prng_step), .prng_in(prng_in)
   );

   always #5 clk = ~clk;

   // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifting left
   function automatic logic [7:0] lfsr(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [7:0] ks(input logic [7:0] s, input int n);
      logic [7:0] v = s;
      for (int i = 0; i < n; i++) v = lfsr(v);
      return v;
   endfunction

   always @(posedge clk) begin
      if (prng_load) gen <= prng_seed;
      else if (prng_step) gen <= lfsr(gen);
   end
   assign prng_in = gen;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ct_valid && ct_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ct_unexpected: got %0h expected none", ct_data);
            end else begin
               chk("ct_data", ct_data, exp_q.pop_front());
            end
            got_q.push_back(ct_data);
         end
         if (done) begin
            done_cnt++;
            chk("done_ct_valid", ct_valid, 0);
         end
         if (prng_step) begin
            step_cnt++;
            chk("step_load_excl", prng_load, 0);
            chk("step_not_stalled", ct_valid && !ct_ready, 0);
         end
         if (prng_load) load_cnt++;
         if (pt_ready) prdy_cnt++;
         if (ct_valid) ctv_cnt++;
      end
   end

   task automatic job(input logic [7:0] s, input logic [7:0] n,
                      input bit fixed, input logic [7:0] fpt,
                      input int rdy_pct, input int vld_pct,
                      input int abort_at, input bit restart);
      int  idx = 0;
      bit  aborted = 0;
      bit  fin = 0;
      done_cnt = 0; step_cnt = 0; load_cnt = 0;
      prdy_cnt = 0; ctv_cnt = 0;
      got_q.delete();
      @(posedge clk); #1;
      start = 1; seed = s; len = n; pt_valid = 0;
      @(posedge clk); #1;
      start = 0; seed = 8'($urandom); len = 8'($urandom);
      chk("load_pulse", prng_load, 1);
      chk("load_pt_ready", pt_ready, 0);
      for (int c = 0; c < 2000 && !fin; c++) begin
         @(posedge clk); #1;
         start = 0;
         if (c == 0) chk("first_pt_ready", pt_ready, n != 0);
         if (busy) chk("bytes_left", bytes_left, 8'(n - idx));
         if (abort_at == idx && busy) begin
            abort = 1; pt_valid = 0; ct_ready = 0;
            @(posedge clk); #1;
            abort = 0;
            exp_q.delete();
            chk("abort_busy", busy, 0);
            chk("abort_ct_valid", ct_valid, 0);
            chk("abort_bytes_left", bytes_left, 0);
            aborted = 1;
            fin = 1;
         end else if (!busy) begin
            fin = 1;
         end else begin
            ct_ready = ($urandom_range(99) < rdy_pct);
            pt_valid = ($urandom_range(99) < vld_pct);
            pt_data  = fixed ? fpt : 8'($urandom);
            if (restart && idx == 1) begin
               start = 1; seed = 8'h11; len = 8'd7;
            end
            #5;
            if (pt_valid && pt_ready) begin
               exp_q.push_back(pt_data ^ ks(s, idx));
               idx++;
            end
         end
      end
      start = 0; pt_valid = 0; ct_ready = 0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL job_timeout: got busy=%0b expected 0", busy);
      end
      chk("done_count", done_cnt, aborted ? 0 : 1);
      chk("step_count", step_cnt, idx);
      chk("load_count", load_cnt, 1);
      chk("queue_empty", exp_q.size(), 0);
      if (!aborted) chk("accepted", idx, n);
      if (n == 0) begin
         chk("zero_pt_ready", prdy_cnt, 0);
         chk("zero_ct_valid", ctv_cnt, 0);
      end
   endtask

   initial begin
      rst = 1; start = 0; seed = 0; len = 0; abort = 0;
      pt_valid = 0; pt_data = 0; ct_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ct_valid", ct_valid, 0);
      chk("rst_pt_ready", pt_ready, 0);
      chk("rst_load", prng_load, 0);
      chk("rst_step", prng_step, 0);
      chk("rst_bytes_left", bytes_left, 0);
      chk("rst_ct_data", ct_data, 0);
      rst = 0;

      job(8'hCD, 8'd3, 1, 8'h00, 100, 100, -1, 0);
      chk("basic_ct0", got_q[0], 8'hCD);
      chk("basic_ct1", got_q[1], 8'h9A);
      chk("basic_ct2", got_q[2], 8'h35);

      job(8'hCD, 8'd3, 1, 8'hFF, 35, 100, -1, 0);
      chk("bp_ct0", got_q[0], 8'h32);
      chk("bp_ct1", got_q[1], 8'h65);
      chk("bp_ct2", got_q[2], 8'hCA);

      job(8'h5A, 8'd0, 0, 8'h00, 100, 100, -1, 0);

      job(8'h77, 8'd5, 0, 8'h00, 100, 100, 2, 0);
      job(8'hCD, 8'd3, 1, 8'h00, 100, 100, -1, 0);
      chk("restart_ct0", got_q[0], 8'hCD);

      job(8'h3C, 8'd6, 0, 8'h00, 70, 80, -1, 1);

      for (int j = 0; j < 25; j++) begin
         job(8'($urandom), 8'($urandom_range(1, 20)), 0, 8'h00,
             $urandom_range(30, 100), $urandom_range(30, 100),
             (j % 7 == 3) ? int'($urandom_range(0, 1)) : -1, j % 5 == 2);
      end
      job(8'hA1, 8'd255, 0, 8'h00, 90, 90, -1, 0);

      @(posedge clk); #1;
      start = 1; seed = 8'h42; len = 8'd10;
      @(posedge clk); #1;
      start = 0;
      @(posedge clk); #1;
      pt_valid = 1; ct_ready = 0; pt_data = 8'h5E;
      @(posedge clk); #3;
      pt_valid = 0;
      chk("pre_rst_ct_valid", ct_valid, 1);
      rst = 1;
      #1;
      chk("arst_ct_valid", ct_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pt_ready", pt_ready, 0);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_bytes_left", bytes_left, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
